bullet_array_sprite: RTL and testbench

Parametrised multi-bullet sprite engine for the battle box. Tracks `NUM_BULLETS` independent round bullets that patrol horizontally between bounds, paced by the frame-end pixel position. Each bullet is killed by its own collision input and respawns after a frame-count delay. Produces a registered per-pixel "on" flag plus the index of the bullet drawn, for the pixel mux and the collision logic.

---
 rtl/bullet_array_sprite.sv | 254 +++++++++++++++++++++++++
 tb/tb_bullet_array_sprite.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_array_sprite.sv
// ============================================================================
// bullet_array_sprite
// ----------------------------------------------------------------------------
// Multi-bullet sprite engine for the battle box. NUM_BULLETS round bullets
// patrol horizontally between X_MIN and X_MAX on fixed rows. The end-of-frame
// pixel position paces them: bullets move once every FRAME_DIV frames. Each
// bullet is killed by its own hit input and respawns at its start position
// after RESPAWN_FRAMES frames. For the pixel mux and the collision logic the
// module produces a registered per-pixel "on" flag and the index of the
// bullet that is drawn there.
//
// Ports
//   Pclk        in   1            pixel clock (25 MHz)
//   rst         in   1            asynchronous active-high reset
//   xx, yy      in   10           current pixel coordinate
//   aactive     in   1            high during the active drawing area
//   hit         in   NUM_BULLETS  per-bullet collision pulse
//   sprite_on   out  1            registered: a live bullet covers (xx,yy)
//   sprite_id   out  3            registered: lowest covering bullet index
//   alive       out  NUM_BULLETS  per-bullet live flag
//   frame_tick  out  1            registered pulse, one cycle after (639,479)
//
// Build option
//   BULLET_ARRAY_BLINK_EN : when defined, a respawned bullet ignores hits for
//   32 frames and during that window is drawn only on frames whose frame
//   count has bit 2 set.
// ============================================================================
module bullet_array_sprite #(
    parameter int NUM_BULLETS    = 4,
    parameter int RADIUS         = 5,
    parameter int X_MIN          = 230,
    parameter int X_MAX          = 410,
    parameter int STEP           = 6,
    parameter int FRAME_DIV      = 3,
    parameter int BASE_X         = 250,
    parameter int X_PITCH        = 40,
    parameter int BASE_Y         = 320,
    parameter int Y_PITCH        = 20,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                   Pclk,
    input  logic                   rst,
    input  logic [9:0]             xx,
    input  logic [9:0]             yy,
    input  logic                   aactive,
    input  logic [NUM_BULLETS-1:0] hit,
    output logic                   sprite_on,
    output logic [2:0]             sprite_id,
    output logic [NUM_BULLETS-1:0] alive,
    output logic                   frame_tick
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int RSP_W = $clog2(RESPAWN_FRAMES + 1);
    localparam logic [22:0] R_SQ = 23'(RADIUS * RADIUS);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [10:0] start_x(input int i);
        return 11'(BASE_X + i * X_PITCH);
    endfunction

    function automatic logic [10:0] row_y(input int i);
        return 11'(BASE_Y + i * Y_PITCH);
    endfunction

    // Reset direction: 1 = moving right. Even bullets start rightwards.
    function automatic logic start_dir(input int i);
        return ((i % 2) == 0);
    endfunction

    // Squared distance from pixel to centre. The 11-bit signed deltas square
    // into 22 bits and the sum fits 23 bits, so no wrap is possible.
    function automatic logic [22:0] dist_sq(input logic [10:0] px,
                                            input logic [10:0] py,
                                            input logic [10:0] cx,
                                            input logic [10:0] cy);
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        logic signed [21:0] dxw;
        logic signed [21:0] dyw;
        logic signed [21:0] sx;
        logic signed [21:0] sy;
        dx  = $signed(px - cx);
        dy  = $signed(py - cy);
        dxw = 22'(dx);
        dyw = 22'(dy);
        sx  = dxw * dxw;
        sy  = dyw * dyw;
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    // One patrol step; returns {new_dir, new_x}. Clamps to the bound and
    // reverses instead of overshooting.
    function automatic logic [11:0] next_pos(input logic [10:0] x,
                                             input logic       dir);
        logic [10:0] nx;
        logic        nd;
        nx = x;
        nd = dir;
        if (dir) begin
            if (x + 11'(STEP) >= 11'(X_MAX)) begin
                nx = 11'(X_MAX);
                nd = 1'b0;
            end else begin
                nx = x + 11'(STEP);
            end
        end else begin
            if (x <= 11'(X_MIN + STEP)) begin
                nx = 11'(X_MIN);
                nd = 1'b1;
            end else begin
                nx = x - 11'(STEP);
            end
        end
        return {nd, nx};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [10:0]            pos         [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] dir;
    logic [RSP_W-1:0]       respawn_cnt [NUM_BULLETS];
    logic [DIV_W-1:0]       div_cnt;

    logic                   tick_now;
    logic                   move_tick;
    logic [NUM_BULLETS-1:0] respawn_now;
    logic [NUM_BULLETS-1:0] hit_ok;
    logic [NUM_BULLETS-1:0] visible;
    logic                   on_p0;
    logic [2:0]             id_p0;

    assign tick_now  = (xx == 10'd639) && (yy == 10'd479);
    // The move fires on the frame tick where the divider wraps back to 0.
    assign move_tick = tick_now && (div_cnt == DIV_W'(FRAME_DIV - 1));

    always_comb begin
        respawn_now = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            respawn_now[i] = !alive[i] && tick_now && (respawn_cnt[i] <= RSP_W'(1));
        end
    end

`ifdef BULLET_ARRAY_BLINK_EN
    localparam int INV_FRAMES = 32;

    logic [5:0] inv_cnt [NUM_BULLETS];
    logic [2:0] frame_cnt;

    // Invulnerability window after respawn, counted in frames.
    always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                inv_cnt[i] <= '0;
            end
        end else if (tick_now) begin
            frame_cnt <= frame_cnt + 3'd1;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (respawn_now[i]) begin
                    inv_cnt[i] <= 6'(INV_FRAMES);
                end else if (inv_cnt[i] != '0) begin
                    inv_cnt[i] <= inv_cnt[i] - 6'd1;
                end
            end
        end
    end

    always_comb begin
        hit_ok  = '0;
        visible = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            hit_ok[i]  = hit[i] && alive[i] && (inv_cnt[i] == '0);
            visible[i] = alive[i] && ((inv_cnt[i] == '0) || frame_cnt[2]);
        end
    end
`else
    always_comb begin
        hit_ok  = hit & alive;
        visible = alive;
    end
`endif

    // ------------------------------------------------------------------
    // Bullet state: divider, movement, kill and respawn
    // ------------------------------------------------------------------
    always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            frame_tick <= 1'b0;
            alive      <= '1;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                pos[i]         <= start_x(i);
                dir[i]         <= start_dir(i);
                respawn_cnt[i] <= '0;
            end
        end else begin
            frame_tick <= tick_now;
            if (tick_now) begin
                div_cnt <= move_tick ? '0 : div_cnt + DIV_W'(1);
            end
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (alive[i]) begin
                    // A kill takes priority over a same-cycle move.
                    if (hit_ok[i]) begin
                        alive[i]       <= 1'b0;
                        respawn_cnt[i] <= RSP_W'(RESPAWN_FRAMES);
                    end else if (move_tick) begin
                        {dir[i], pos[i]} <= next_pos(pos[i], dir[i]);
                    end
                end else if (tick_now) begin
                    // Dead bullets count down every frame, not divided.
                    if (respawn_now[i]) begin
                        alive[i]       <= 1'b1;
                        pos[i]         <= start_x(i);
                        dir[i]         <= start_dir(i);
                        respawn_cnt[i] <= '0;
                    end else begin
                        respawn_cnt[i] <= respawn_cnt[i] - RSP_W'(1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Draw: coverage test, lowest index wins
    // ------------------------------------------------------------------
    always_comb begin
        on_p0 = 1'b0;
        id_p0 = 3'd0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (visible[i] &&
                dist_sq({1'b0, xx}, {1'b0, yy}, pos[i], row_y(i)) <= R_SQ) begin
                on_p0 = 1'b1;
                id_p0 = 3'(i);
            end
        end
    end

    always_ff @(posedge Pclk or posedge rst) begin
        if (rst) begin
            sprite_on <= 1'b0;
            sprite_id <= 3'd0;
        end else begin
            sprite_on <= aactive & on_p0;
            sprite_id <= id_p0;
        end
    end

endmodule

// File: tb/tb_bullet_array_sprite.sv
module tb_bullet_array_sprite;

    logic       Pclk = 1'b0;
    logic       rst;
    logic [9:0] xx;
    logic [9:0] yy;
    logic       aactive;
    logic [3:0] hit;
    logic       sprite_on;
    logic [2:0] sprite_id;
    logic [3:0] alive;
    logic       frame_tick;

    logic [1:0] ovl_hit;
    logic       ovl_on;
    logic [2:0] ovl_id;
    logic [1:0] ovl_alive;
    logic       ovl_tick;

    int n_total = 0;
    int n_pass  = 0;

    always #20 Pclk = ~Pclk;

    bullet_array_sprite dut (
        .Pclk       (Pclk),
        .rst        (rst),
        .xx         (xx),
        .yy         (yy),
        .aactive    (aactive),
        .hit        (hit),
        .sprite_on  (sprite_on),
        .sprite_id  (sprite_id),
        .alive      (alive),
        .frame_tick (frame_tick)
    );

    bullet_array_sprite #(
        .NUM_BULLETS (2),
        .X_PITCH     (0),
        .Y_PITCH     (0)
    ) u_ovl (
        .Pclk       (Pclk),
        .rst        (rst),
        .xx         (xx),
        .yy         (yy),
        .aactive    (aactive),
        .hit        (ovl_hit),
        .sprite_on  (ovl_on),
        .sprite_id  (ovl_id),
        .alive      (ovl_alive),
        .frame_tick (ovl_tick)
    );

    typedef struct {
        int         x;
        int         y;
        logic       a;
        logic       on;
        logic [2:0] id;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Present a pixel, let it be registered, sample just after the edge.
    task automatic drive_pix(input int x, input int y, input logic a);
        @(negedge Pclk);
        xx = 10'(x);
        yy = 10'(y);
        aactive = a;
        @(posedge Pclk);
        #1;
    endtask

    task automatic probe(input string name, input int x, input int y,
                         input logic exp_on, input logic [2:0] exp_id);
        drive_pix(x, y, 1'b1);
        chk({name, "_on"}, 32'(sprite_on), 32'(exp_on));
        if (exp_on) chk({name, "_id"}, 32'(sprite_id), 32'(exp_id));
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Pclk);
            xx = 10'd639;
            yy = 10'd479;
            @(negedge Pclk);
            xx = 10'd0;
            yy = 10'd0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_alive;

        // Bullets at reset: (250,320) (290,340) (330,360) (370,380), r=5
        vecs[0]  = '{255, 320, 1'b1, 1'b1, 3'd0};
        vecs[1]  = '{256, 320, 1'b1, 1'b0, 3'd0};
        vecs[2]  = '{250, 320, 1'b0, 1'b0, 3'd0};
        vecs[3]  = '{250, 320, 1'b1, 1'b1, 3'd0};
        vecs[4]  = '{253, 324, 1'b1, 1'b1, 3'd0};
        vecs[5]  = '{254, 324, 1'b1, 1'b0, 3'd0};
        vecs[6]  = '{245, 320, 1'b1, 1'b1, 3'd0};
        vecs[7]  = '{290, 340, 1'b1, 1'b1, 3'd1};
        vecs[8]  = '{290, 335, 1'b1, 1'b1, 3'd1};
        vecs[9]  = '{330, 360, 1'b1, 1'b1, 3'd2};
        vecs[10] = '{370, 385, 1'b1, 1'b1, 3'd3};
        vecs[11] = '{370, 386, 1'b1, 1'b0, 3'd0};
        vecs[12] = '{0,   0,   1'b1, 1'b0, 3'd0};

        rst = 1'b1; xx = '0; yy = '0; aactive = 1'b0; hit = '0; ovl_hit = '0;
        repeat (3) @(posedge Pclk);
        #1;
        chk("rst_sprite_on", 32'(sprite_on), 32'd0);
        chk("rst_sprite_id", 32'(sprite_id), 32'd0);
        chk("rst_alive", 32'(alive), 32'hF);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        @(negedge Pclk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive_pix(vecs[i].x, vecs[i].y, vecs[i].a);
            chk($sformatf("vec%0d_on", i), 32'(sprite_on), 32'(vecs[i].on));
            chk($sformatf("vec%0d_id", i), 32'(sprite_id), 32'(vecs[i].id));
        end

        // Two frame ticks: no move yet.
        frames(2);
        probe("div2_b0_in", 255, 320, 1'b1, 3'd0);
        probe("div2_b0_out", 256, 320, 1'b0, 3'd0);

        // Third tick: frame_tick pulse, then a move.
        @(negedge Pclk);
        xx = 10'd639; yy = 10'd479;
        @(posedge Pclk); #1;
        chk("frame_tick_hi", 32'(frame_tick), 32'd1);
        @(negedge Pclk);
        xx = 10'd0; yy = 10'd0;
        @(posedge Pclk); #1;
        chk("frame_tick_lo", 32'(frame_tick), 32'd0);

        // After 1 move: b0=256, b1=284, b2=336, b3=364
        probe("mv1_b0_r", 261, 320, 1'b1, 3'd0);
        probe("mv1_b0_r_out", 262, 320, 1'b0, 3'd0);
        probe("mv1_b0_l", 251, 320, 1'b1, 3'd0);
        probe("mv1_b0_l_out", 250, 320, 1'b0, 3'd0);
        probe("mv1_b1_in", 289, 340, 1'b1, 3'd1);
        probe("mv1_b1_out", 290, 340, 1'b0, 3'd0);

        // 10 moves: b1 clamped to X_MIN=230
        frames(27);
        probe("mv10_b1_in", 225, 340, 1'b1, 3'd1);
        probe("mv10_b1_out", 224, 340, 1'b0, 3'd0);

        // 13 moves: b2 at 408
        frames(9);
        probe("mv13_b2_in", 413, 360, 1'b1, 3'd2);
        probe("mv13_b2_out", 414, 360, 1'b0, 3'd0);
        // 14 moves: clamped to 410
        frames(3);
        probe("mv14_b2_in", 415, 360, 1'b1, 3'd2);
        probe("mv14_b2_out", 416, 360, 1'b0, 3'd0);
        // 15 moves: reversed to 404
        frames(3);
        probe("mv15_b2_in", 409, 360, 1'b1, 3'd2);
        probe("mv15_b2_out", 410, 360, 1'b0, 3'd0);

        // Kill bullet 1 (now at 260,340); the hit-cycle pixel uses old alive.
        @(negedge Pclk);
        xx = 10'd260; yy = 10'd340; aactive = 1'b1; hit = 4'b0010;
        @(posedge Pclk); #1;
        chk("hit_cycle_draw", 32'(sprite_on), 32'd1);
        chk("alive_after_hit", 32'(alive), 32'hD);
        @(negedge Pclk);
        hit = 4'b0000;
        @(posedge Pclk); #1;
        chk("dead_no_draw", 32'(sprite_on), 32'd0);
        probe("dead_no_draw_start", 290, 340, 1'b0, 3'd0);

        frames(10);
        @(negedge Pclk);
        hit = 4'b0010;
        @(negedge Pclk);
        hit = 4'b0000;
        @(posedge Pclk); #1;
        chk("hit_while_dead", 32'(alive), 32'hD);
        frames(49);
        @(posedge Pclk); #1;
        chk("alive_after_59", 32'(alive), 32'hD);
        frames(1);
        @(posedge Pclk); #1;
        chk("alive_after_60", 32'(alive), 32'hF);
`ifdef BULLET_ARRAY_BLINK_EN
        // 105 frames elapsed: frame-count bit 2 is 0, so hidden.
        probe("respawn_pos_in", 295, 340, 1'b0, 3'd0);
`else
        probe("respawn_pos_in", 295, 340, 1'b1, 3'd1);
`endif
        probe("respawn_pos_out", 296, 340, 1'b0, 3'd0);

        // Hit right after respawn.
        @(negedge Pclk);
        hit = 4'b0010;
        @(negedge Pclk);
        hit = 4'b0000;
        @(posedge Pclk); #1;
`ifdef BULLET_ARRAY_BLINK_EN
        exp_alive = 4'hF;
`else
        exp_alive = 4'hD;
`endif
        chk("hit_after_respawn", 32'(alive), 32'(exp_alive));

        // Kill bullet 2, then reset mid-frame on a tick cycle.
        @(negedge Pclk);
        hit = 4'b0100;
        @(negedge Pclk);
        hit = 4'b0000;
        @(posedge Pclk); #1;
        exp_alive[2] = 1'b0;
        chk("alive_b2_killed", 32'(alive), 32'(exp_alive));

        @(negedge Pclk);
        xx = 10'd639; yy = 10'd479; aactive = 1'b1;
        #5 rst = 1'b1;
        #1;
        chk("async_rst_alive", 32'(alive), 32'hF);
        chk("async_rst_on", 32'(sprite_on), 32'd0);
        chk("async_rst_tick", 32'(frame_tick), 32'd0);
        @(negedge Pclk);
        xx = 10'd250; yy = 10'd320;
        @(posedge Pclk); #1;
        chk("rst_held_on", 32'(sprite_on), 32'd0);
        @(negedge Pclk);
        rst = 1'b0;
        @(posedge Pclk); #1;
        chk("post_rst_on", 32'(sprite_on), 32'd1);
        chk("post_rst_id", 32'(sprite_id), 32'd0);
        probe("post_rst_b0_out", 256, 320, 1'b0, 3'd0);
        probe("post_rst_b3_in", 375, 380, 1'b1, 3'd3);
        probe("post_rst_b3_out", 376, 380, 1'b0, 3'd0);

        // Overlap instance: both bullets at (250,320).
        drive_pix(250, 320, 1'b1);
        chk("ovl_on", 32'(ovl_on), 32'd1);
        chk("ovl_id0", 32'(ovl_id), 32'd0);
        @(negedge Pclk);
        ovl_hit = 2'b01;
        @(negedge Pclk);
        ovl_hit = 2'b00;
        @(posedge Pclk); #1;
        chk("ovl_alive", 32'(ovl_alive), 32'h2);
        chk("ovl_on_after_kill", 32'(ovl_on), 32'd1);
        chk("ovl_id1", 32'(ovl_id), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
